// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store front end for the tri-state word memory
// Optional read-modify-write for byte/half stores: define MEM_ACCESS_RMW_EN.
module mem_access_unit #(
  parameter int N           = 30,
  parameter int M           = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [1:0]   req_size,
  input  logic [31:0]  req_wdata,
  output logic         resp_valid,
  output logic [31:0]  resp_rdata,
  output logic         resp_error,
  output logic [N-1:0] mem_address,
  output logic         mem_write_read_not,
  output logic         mem_enable,
  inout  wire  [M-1:0] mem_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RMW_MERGE, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  lane;
  logic [1:0]  size_q;
  logic        write_q;
  logic [M-1:0] bus_data;
  logic        req_err;
  logic        unused_addr;

`ifdef MEM_ACCESS_RMW_EN
  logic        rmw_read;
`endif

  // The bus is driven exactly while write_read_not is high, including the
  // release cycle in RESP, so the memory never sees a floating write.
  assign mem_data    = mem_write_read_not ? bus_data : {M{1'bz}};
  assign unused_addr = ^req_addr;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
`ifndef MEM_ACCESS_RMW_EN
    if (req_write && req_size != 2'b10)
      req_err = 1'b1;
`endif
  end

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] s);
    logic [31:0] r;
    case (s)
      2'b00:   r = {24'd0, w[{a, 3'b000} +: 8]};
      2'b01:   r = a[1] ? {16'd0, w[31:16]} : {16'd0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

`ifdef MEM_ACCESS_RMW_EN
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] a, input logic [1:0] s);
    logic [31:0] r;
    r = w;
    case (s)
      2'b00: r[{a, 3'b000} +: 8] = d[7:0];
      2'b01: begin
        if (a[1]) r[31:16] = d[15:0];
        else      r[15:0]  = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= 4'd0;
      lane               <= 2'd0;
      size_q             <= 2'd0;
      write_q            <= 1'b0;
      bus_data           <= '0;
      req_ready          <= 1'b1;
      resp_valid         <= 1'b0;
      resp_error         <= 1'b0;
      resp_rdata         <= 32'd0;
      mem_address        <= '0;
      mem_write_read_not <= 1'b0;
      mem_enable         <= 1'b0;
`ifdef MEM_ACCESS_RMW_EN
      rmw_read           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready   <= 1'b0;
            lane        <= req_addr[1:0];
            size_q      <= req_size;
            write_q     <= req_write;
            mem_address <= req_addr[N+1:2];
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state      <= ACCESS;
              cnt        <= WAIT_INIT;
              mem_enable <= 1'b1;
              bus_data   <= req_wdata;
`ifdef MEM_ACCESS_RMW_EN
              // Sub-word stores first read the word they modify.
              rmw_read           <= req_write && req_size != 2'b10;
              mem_write_read_not <= req_write && req_size == 2'b10;
`else
              mem_write_read_not <= req_write;
`endif
            end
          end
        end

        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
`ifdef MEM_ACCESS_RMW_EN
          else if (rmw_read) begin
            mem_enable <= 1'b0;
            rmw_read   <= 1'b0;
            bus_data   <= merge(mem_data, bus_data, lane, size_q);
            state      <= RMW_MERGE;
          end
`endif
          else begin
            mem_enable <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= write_q ? 32'd0 : extract(mem_data, lane, size_q);
          end
        end

`ifdef MEM_ACCESS_RMW_EN
        RMW_MERGE: begin
          state              <= ACCESS;
          cnt                <= WAIT_INIT;
          mem_enable         <= 1'b1;
          mem_write_read_not <= 1'b1;
        end
`endif

        RESP: begin
          // write_read_not only drops here, after enable fell a cycle earlier.
          state              <= IDLE;
          req_ready          <= 1'b1;
          resp_valid         <= 1'b0;
          resp_error         <= 1'b0;
          resp_rdata         <= 32'd0;
          mem_write_read_not <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed and back-to-back bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [29:0] mem_address;
  logic        mem_write_read_not;
  logic        mem_enable;
  wire  [31:0] mem_data;

  int checks = 0;
  int errors = 0;
  logic mon_on = 1'b0;

  logic [31:0] mem     [0:63];
  logic [31:0] exp_mem [0:63];

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_write_read_not(mem_write_read_not),
    .mem_enable(mem_enable), .mem_data(mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data = (mem_enable && !mem_write_read_not) ? mem[mem_address[5:0]] : 32'bz;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    forever begin
      @(posedge clk);
      if (mem_enable && mem_write_read_not) mem[mem_address[5:0]] = mem_data;
    end
  end

  // Bus protocol watch while traffic runs back to back.
  initial begin
    logic prev_en;
    logic prev_wrn;
    prev_en  = 1'b0;
    prev_wrn = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        checks++;
        if (prev_en && prev_wrn && !mem_write_read_not) begin
          errors++;
          $display("FAIL wrn_fall_while_enabled: wrn=%0b prev_en=%0b required no fall", mem_write_read_not, prev_en);
        end
        if (mem_enable && !mem_write_read_not) begin
          checks++;
          if (mem_data !== mem[mem_address[5:0]]) begin
            errors++;
            $display("FAIL bus_contention: mem_data=%h required %h", mem_data, mem[mem_address[5:0]]);
          end
        end
      end
      prev_en  = mem_enable;
      prev_wrn = mem_write_read_not;
    end
  end

  function automatic logic [31:0] lane_of(input logic [31:0] w, input logic [31:0] a, input logic [1:0] s);
    if (s == 2'b00) return (w >> (8 * a[1:0])) & 32'h0000_00FF;
    if (s == 2'b01) return (w >> (16 * a[1])) & 32'h0000_FFFF;
    return w;
  endfunction

  function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] s, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (s == 2'b00) begin mask = 32'hFF;   sh = 8 * a[1:0]; end
    else            begin mask = 32'hFFFF; sh = 16 * a[1]; end
    return (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er, output logic en);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_write = w; req_addr = a; req_size = s; req_wdata = d; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    en  = mem_enable;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      en = en | mem_enable;
    end
    rd = resp_rdata;
    er = resp_error;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b required 0", resp_valid); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL rst_resp_error: got %b required 0", resp_error); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_resp_rdata: got %h required 0", resp_rdata); end
    checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL rst_mem_enable: got %b required 0", mem_enable); end
    checks++; if (mem_write_read_not !== 1'b0) begin errors++; $display("FAIL rst_wrn: got %b required 0", mem_write_read_not); end
    checks++; if (mem_address !== 30'd0) begin errors++; $display("FAIL rst_mem_address: got %h required 0", mem_address); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_word;
    int lat; logic [31:0] rd; logic er; logic en;
    do_req(1'b1, 32'h0000_000C, 2'b10, 32'hDEAD_BEEF, lat, rd, er, en);
    exp_mem[3] = 32'hDEAD_BEEF;
    checks++; if (lat != 3) begin errors++; $display("FAIL store_word_latency: got %0d required 3", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_word_error: got %b required 0", er); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL store_word_rdata: got %h required 0", rd); end
    do_req(1'b0, 32'h0000_000C, 2'b10, 32'd0, lat, rd, er, en);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_word_data: got %h required deadbeef", rd); end
    checks++; if (lat != 3) begin errors++; $display("FAIL load_word_latency: got %0d required 3", lat); end
  endtask

  task automatic test_subword_load;
    int lat; logic [31:0] rd; logic er; logic en;
    do_req(1'b0, 32'h0000_000E, 2'b00, 32'd0, lat, rd, er, en);
    checks++; if (rd !== 32'h0000_00AD || er !== 1'b0) begin errors++; $display("FAIL load_byte: got %h err %b required 000000ad err 0", rd, er); end
    do_req(1'b0, 32'h0000_000C, 2'b01, 32'd0, lat, rd, er, en);
    checks++; if (rd !== 32'h0000_BEEF || er !== 1'b0) begin errors++; $display("FAIL load_half: got %h err %b required 0000beef err 0", rd, er); end
    do_req(1'b0, 32'h0000_000F, 2'b00, 32'd0, lat, rd, er, en);
    checks++; if (rd !== 32'h0000_00DE) begin errors++; $display("FAIL load_byte_top: got %h required 000000de", rd); end
  endtask

  task automatic test_errors;
    int lat; logic [31:0] rd; logic er; logic en;
    do_req(1'b0, 32'h0000_003D, 2'b10, 32'd0, lat, rd, er, en);
    checks++; if (er !== 1'b1 || lat != 1) begin errors++; $display("FAIL misaligned_word: err %b lat %0d required err 1 lat 1", er, lat); end
    checks++; if (rd !== 32'd0 || en !== 1'b0) begin errors++; $display("FAIL misaligned_word_bus: rdata %h enable_seen %b required 0 0", rd, en); end
    do_req(1'b0, 32'h0000_0010, 2'b11, 32'd0, lat, rd, er, en);
    checks++; if (er !== 1'b1 || lat != 1) begin errors++; $display("FAIL size11: err %b lat %0d required err 1 lat 1", er, lat); end
    checks++; if (rd !== 32'd0 || en !== 1'b0) begin errors++; $display("FAIL size11_bus: rdata %h enable_seen %b required 0 0", rd, en); end
    do_req(1'b0, 32'h0000_0011, 2'b01, 32'd0, lat, rd, er, en);
    checks++; if (er !== 1'b1 || en !== 1'b0) begin errors++; $display("FAIL misaligned_half: err %b enable_seen %b required 1 0", er, en); end
  endtask

  task automatic test_subword_store;
    int lat; logic [31:0] rd; logic er; logic en;
    do_req(1'b1, 32'h0000_000E, 2'b01, 32'h0000_1234, lat, rd, er, en);
`ifdef MEM_ACCESS_RMW_EN
    exp_mem[3] = 32'h1234_BEEF;
    checks++; if (er !== 1'b0 || lat != 6) begin errors++; $display("FAIL rmw_store: err %b lat %0d required err 0 lat 6", er, lat); end
`else
    checks++; if (er !== 1'b1 || lat != 1 || en !== 1'b0) begin errors++; $display("FAIL half_store_rejected: err %b lat %0d en %b required 1 1 0", er, lat, en); end
`endif
    do_req(1'b0, 32'h0000_000C, 2'b10, 32'd0, lat, rd, er, en);
    checks++; if (rd !== exp_mem[3]) begin errors++; $display("FAIL word_after_half_store: got %h required %h", rd, exp_mem[3]); end
  endtask

  task automatic test_back_to_back;
    logic w; logic [1:0] s; logic [31:0] a; logic [31:0] d;
    logic [31:0] exp_rd; logic exp_er; int lat; logic got;
    mon_on = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 15)) * 4;
      if (s == 2'b00) a = a + 32'($urandom_range(0, 3));
      if (s == 2'b01) a = a + 32'(2 * $urandom_range(0, 1));
      d = $urandom;
      exp_rd = 32'd0;
      exp_er = 1'b0;
      if (!w) exp_rd = lane_of(exp_mem[a[7:2]], a, s);
      else if (s == 2'b10) exp_mem[a[7:2]] = d;
      else begin
`ifdef MEM_ACCESS_RMW_EN
        exp_mem[a[7:2]] = put_lane(exp_mem[a[7:2]], a, s, d);
`else
        exp_er = 1'b1;
`endif
      end
      req_write = w; req_addr = a; req_size = s; req_wdata = d; req_valid = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
        if (resp_valid) got = 1'b1;
      end
      checks++;
      if (!got || resp_error !== exp_er || resp_rdata !== exp_rd) begin
        errors++;
        $display("FAIL b2b_op%0d: resp %b err %b rdata %h required resp 1 err %b rdata %h", i, got, resp_error, resp_rdata, exp_er, exp_rd);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    mon_on = 1'b0;
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h0000_00A0; req_size = 2'b10; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (mem_enable !== 1'b0 || mem_write_read_not !== 1'b0) begin errors++; $display("FAIL mid_reset_bus: en %b wrn %b required 0 0", mem_enable, mem_write_read_not); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b required 1", req_ready); end
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_reset_no_resp: got %0d responses required 0", seen); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 32'd0; req_size = 2'b00; req_wdata = 32'd0;
    for (int i = 0; i < 64; i++) exp_mem[i] = 32'd0;
    test_reset;
    test_word;
    test_subword_load;
    test_errors;
    test_subword_store;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Request/response front end for the word-addressed, tri-state-data Memory block.
- Takes byte-addressed load/store requests from the CPU datapath over a valid/ready handshake.
- Sequences the Memory's address, write_read_not, enable and bidirectional data lines with a programmable access time.
- Returns aligned load data, or an error, as a one-cycle response pulse.

Parameters:
- N, 30, word-address width passed to Memory (N <= 30)
- M, 32, word width; fixed at 32 for lane selection
- WAIT_CYCLES, 1, extra cycles Memory lines are held before sampling/release (0..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  zero-extended load data; 0 for stores and errors
- resp_error  out  1  valid with resp_valid
- mem_address  out  N  to Memory address
- mem_write_read_not  out  1  to Memory write_read_not
- mem_enable  out  1  to Memory enable
- mem_data  inout  M  to Memory data

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0.
  - mem_enable=0, mem_write_read_not=0, mem_address=0.
  - mem_data released (Z).
- States: IDLE, ACCESS, RMW_MERGE (macro only), RESP. All outputs are registered.
- Handshake:
  - req_ready=1 only in IDLE.
  - Request is accepted on an edge where req_valid && req_ready; addr, size, write and wdata are captured.
  - req_valid while busy is ignored; no queuing.
- Error check at accept:
  - Error cases: size=11; half with addr[0]=1; word with addr[1:0]!=0.
  - Go straight to RESP with resp_error=1 and resp_rdata=0.
  - Memory lines are never enabled.
- Word address: mem_address = req_addr[N+1:2]; upper address bits are ignored.
- ACCESS:
  - Lasts WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter.
  - mem_enable=1; mem_address held; mem_write_read_not = req_write.
  - Load: mem_data is sampled on the last ACCESS edge.
- Bus rule: the unit drives mem_data if and only if mem_write_read_not=1; otherwise Z.
- Store release:
  - In RESP after a store, hold mem_enable=0, mem_write_read_not=1 and data driven for that cycle.
  - Return to mem_write_read_not=0 on entry to IDLE, so write_read_not never falls while enable=1.
- Load lanes (little-endian):
  - byte: lane addr[1:0], zero-extended.
  - half: lane addr[1], zero-extended.
  - word: whole word.
- Latency: resp_valid rises exactly WAIT_CYCLES+2 edges after the accept edge for a word store or any load. Errors respond 1 edge after accept.
- RESP: lasts 1 cycle (resp_valid=1), then IDLE with req_ready=1. The earliest next accept is 1 edge after RESP.
- Reset mid-operation: the next edge forces IDLE and reset values. Any pending response is dropped and no response is ever issued for it.

Optional Feature:
- Macro: MEM_ACCESS_RMW_EN.
- Defined: byte/half stores are performed as read-modify-write:
  - ACCESS read phase (WAIT_CYCLES+1 cycles).
  - RMW_MERGE for 1 cycle, with mem_enable=0 and the lane replaced.
  - ACCESS write phase, then RESP.
  - Latency is 2*WAIT_CYCLES+4 edges.
- Undefined: byte/half stores respond with resp_error=1 after 1 edge and no memory access. Sub-word loads are unaffected.

Test Plan:
- Store word 0xDEADBEEF at 0x0000000C, WAIT_CYCLES=1 -> resp_valid exactly 3 edges after accept, error 0. Then load word 0x0C -> resp_rdata=0xDEADBEEF.
- After the above, load byte 0x0000000E -> 0x000000AD. Load half 0x0000000C -> 0x0000BEEF.
- Load word 0x0000003D; separately, req_size=11 -> resp_error=1 one edge after accept, resp_rdata=0, mem_enable never 1.
- Store half 0x1234 at 0x0E:
  - Macro defined -> latency 6, then word 0x0C reads 0x1234BEEF.
  - Macro undefined -> error, and word 0x0C still reads 0xDEADBEEF.
- Assert reset during the ACCESS cycle of a store -> next edge mem_enable=0, mem_write_read_not=0, req_ready=1, and no resp_valid afterwards.
- Random back-to-back loads/stores with req_valid held high -> assert: mem_data never driven when mem_write_read_not=0, and mem_write_read_not never falls while mem_enable=1.
